// File: rtl/passcode_lock_ctrl.sv
// Four-digit passcode lock: digit entry handshake, compare, timed open window,
// key reprogramming and a timed lockout after repeated wrong entries.
module passcode_lock_ctrl #(
  // Digits 1,2,4,8 packed as 5-bit fields, digit0 in [4:0]
  parameter logic [19:0] DEFAULT_KEY    = {5'd8, 5'd4, 5'd2, 5'd1},
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 16,
  parameter int          OPEN_CYCLES    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        code_valid,
  input  logic [31:0] code_in,
  output logic        code_ready,
  input  logic        prog_en,
  input  logic        lock_cmd,
  output logic        unlocked,
  output logic        alarm,
  output logic        invalid_code,
  output logic [1:0]  fail_cnt,
  output logic [2:0]  state
);

  localparam int MAX_T = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW    = $clog2(MAX_T + 1);
  localparam logic [TW-1:0] OPEN_LOAD    = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_PROG    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [19:0]   key_q, key_d;
  logic [19:0]   entry_q, entry_d;
  logic [19:0]   shadow_q, shadow_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ready_q, ready_d;
  logic          unlocked_q, unlocked_d;
  logic          alarm_q, alarm_d;
  logic          invalid_q, invalid_d;

  logic       accept;
  logic       digit_ok;
  logic [1:0] fail_inc;

  assign accept   = code_valid & ready_q;
  assign digit_ok = (code_in[31:5] == 27'd0);
  assign fail_inc = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    entry_d   = entry_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    fail_d    = fail_q;
    timer_d   = timer_q;
    invalid_d = accept & ~digit_ok;

    case (state_q)
      S_LOCKED: begin
        if (accept && digit_ok) begin
          entry_d[5*idx_q +: 5] = code_in[4:0];
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (entry_q == key_q) begin
          state_d = S_OPEN;
          fail_d  = 2'd0;
          timer_d = OPEN_LOAD;
        end else begin
          fail_d = fail_inc;
          if (int'(fail_inc) == MAX_FAILS) begin
            state_d = S_LOCKOUT;
            timer_d = LOCKOUT_LOAD;
          end else begin
            state_d = S_LOCKED;
          end
        end
      end
      S_OPEN: begin
        if (lock_cmd)                state_d = S_LOCKED;
        else if (prog_en)            state_d = S_PROG;
        else if (timer_q == '0)      state_d = S_LOCKED;
        else                         timer_d = timer_q - TW'(1);
      end
      S_PROG: begin
        if (accept && digit_ok) begin
          shadow_d[5*idx_q +: 5] = code_in[4:0];
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            key_d   = shadow_d;
            state_d = S_LOCKED;
          end
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_LOCKED;
          fail_d  = 2'd0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_LOCKED;
    endcase

    // Any fresh entry into a digit-collecting state drops a partial code
    if ((state_d != state_q) && ((state_d == S_LOCKED) || (state_d == S_PROG)))
      idx_d = 2'd0;

    ready_d    = (state_d == S_LOCKED) || (state_d == S_PROG);
    unlocked_d = (state_d == S_OPEN) || (state_d == S_PROG);
    alarm_d    = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOCKED;
      key_q      <= DEFAULT_KEY;
      entry_q    <= 20'd0;
      shadow_q   <= 20'd0;
      idx_q      <= 2'd0;
      fail_q     <= 2'd0;
      timer_q    <= '0;
      ready_q    <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      entry_q    <= entry_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      ready_q    <= ready_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      invalid_q  <= invalid_d;
    end
  end

  assign code_ready   = ready_q;
  assign unlocked     = unlocked_q;
  assign alarm        = alarm_q;
  assign invalid_code = invalid_q;
  assign fail_cnt     = fail_q;
  assign state        = state_q;

endmodule
